// File: rtl/fetch_queue.sv
// Instruction prefetch queue: drives the fetch PC, buffers {pc, instr} pairs, and presents the oldest to decode.
// Latency: a word fetched at edge N is at the head right after edge N when the queue was empty; head is combinational.
// Backpressure: out_ready=0 holds the head stable; when full, fetch stalls unless a pop frees a slot the same cycle.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     fetch_en,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Entry storage; never reset because the head is gated by occupancy.
  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic pop;
  logic push;
  logic not_full;

  // The low redirect bits are dropped; instructions are word aligned.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign not_full = (count_q < CW'(DEPTH));
  assign pop      = out_valid & out_ready;
  // A full queue may still accept a word when the head leaves in the same cycle.
  assign push     = fetch_en & ~redirect_valid & (not_full | pop);

  // Next-state for PC, pointers and occupancy; redirect flushes everything.
  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // Control state registers with synchronous reset overriding everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Capture the fetched word together with the address it came from.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= pc_q;
    end
  end

  assign imem_addr = pc_q;
  assign count     = count_q;
  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? instr_mem[rd_ptr_q] : NOP;
  assign out_pc    = out_valid ? pc_mem[rd_ptr_q]    : 32'h0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill, stream, full push+pop, redirect, fetch stall, wrap and mid-stream reset.
// Memory model returns a PC-derived word so every head entry is checkable against its address.
// Expected values are hand-computed constants.
module tb_fetch_queue;

  localparam logic [31:0] PAT = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (RESET_PC = 0)
  logic        reset, fetch_en, redirect_valid, out_ready, out_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, out_instr, out_pc;
  logic [2:0]  count;

  // Wrap instance (RESET_PC = 0xFFFFFFF8)
  logic        w_reset, w_fetch_en, w_redirect_valid, w_out_ready, w_out_valid;
  logic [31:0] w_imem_addr, w_imem_rdata, w_redirect_pc, w_out_instr, w_out_pc;
  logic [2:0]  w_count;

  assign imem_rdata   = imem_addr ^ PAT;
  assign w_imem_rdata = w_imem_addr ^ PAT;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000), .NOP(NOP)) u_dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .count(count)
  );

  fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .NOP(NOP)) u_dut_wrap (
    .clk(clk), .reset(w_reset), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
    .fetch_en(w_fetch_en), .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .out_valid(w_out_valid), .out_instr(w_out_instr), .out_pc(w_out_pc),
    .out_ready(w_out_ready), .count(w_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the head of the main instance.
  task automatic check_head(input string tag, input logic vld, input logic [31:0] pc,
                            input logic [2:0] cnt);
    check_val({tag, "_vld"}, {31'b0, out_valid}, {31'b0, vld});
    check_val({tag, "_pc"}, out_pc, vld ? pc : 32'h0);
    check_val({tag, "_instr"}, out_instr, vld ? (pc ^ PAT) : NOP);
    check_val({tag, "_cnt"}, {29'b0, count}, {29'b0, cnt});
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    w_reset = 1'b1; w_fetch_en = 1'b0; w_redirect_valid = 1'b0; w_redirect_pc = 32'h0; w_out_ready = 1'b0;
    step(); step();

    // Reset state
    check_head("rst", 1'b0, 32'h0, 3'd0);
    check_val("rst_addr", imem_addr, 32'h0);
    check_val("wrst_addr", w_imem_addr, 32'hFFFF_FFF8);

    // Fill: fetch with decode stalled
    reset = 1'b0; fetch_en = 1'b1;
    step();
    check_head("fill1", 1'b1, 32'h0, 3'd1);
    step(); step(); step();
    check_head("fill4", 1'b1, 32'h0, 3'd4);
    check_val("fill4_addr", imem_addr, 32'h10);
    step();
    check_val("full_hold_addr", imem_addr, 32'h10);
    check_val("full_hold_cnt", {29'b0, count}, 32'd4);

    // Full push+pop in one cycle
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_head("fullpp", 1'b1, 32'h4, 3'd4);
    check_val("fullpp_addr", imem_addr, 32'h14);
    step();
    check_head("stable", 1'b1, 32'h4, 3'd4);

    // Redirect while full, with a pop attempted the same cycle
    redirect_valid = 1'b1; redirect_pc = 32'h102; out_ready = 1'b1;
    step();
    redirect_valid = 1'b0; out_ready = 1'b0;
    check_head("redir1", 1'b0, 32'h0, 3'd0);
    check_val("redir1_addr", imem_addr, 32'h100);
    step();
    check_head("redir2", 1'b1, 32'h100, 3'd1);
    check_val("redir2_addr", imem_addr, 32'h104);

    // Stall fetch with three entries and drain them
    step(); step();
    check_head("pre_stall", 1'b1, 32'h100, 3'd3);
    fetch_en = 1'b0; out_ready = 1'b1;
    step();
    check_head("stall1", 1'b1, 32'h104, 3'd2);
    step();
    check_head("stall2", 1'b1, 32'h108, 3'd1);
    step();
    check_head("stall3", 1'b0, 32'h0, 3'd0);
    check_val("stall_addr", imem_addr, 32'h10C);
    step();
    check_head("stall_empty", 1'b0, 32'h0, 3'd0);

    // Stream from reset: one entry in flight, PC advancing each cycle
    reset = 1'b1;
    step();
    check_val("rst2_addr", imem_addr, 32'h0);
    reset = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_head($sformatf("stream%0d", i), 1'b1, 32'(i * 4), 3'd1);
    end

    // Wrap past 2^32 then reset with two entries queued
    w_reset = 1'b0; w_fetch_en = 1'b1; w_out_ready = 1'b1;
    step();
    check_val("wrap0_pc", w_out_pc, 32'hFFFF_FFF8);
    step();
    check_val("wrap1_pc", w_out_pc, 32'hFFFF_FFFC);
    check_val("wrap1_instr", w_out_instr, 32'hFFFF_FFFC ^ PAT);
    step();
    check_val("wrap2_pc", w_out_pc, 32'h0);
    check_val("wrap2_instr", w_out_instr, PAT);
    check_val("wrap2_addr", w_imem_addr, 32'h4);
    w_out_ready = 1'b0;
    step();
    check_val("wrap_cnt2", {29'b0, w_count}, 32'd2);
    w_reset = 1'b1;
    step();
    check_val("wrap_rst_cnt", {29'b0, w_count}, 32'd0);
    check_val("wrap_rst_addr", w_imem_addr, 32'hFFFF_FFF8);
    check_val("wrap_rst_vld", {31'b0, w_out_valid}, 32'd0);
    check_val("wrap_rst_instr", w_out_instr, NOP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
